// File: rtl/scan_checker.sv
// scan_checker: walks a 16-entry table through the fetch stage, summing the
// data bytes and counting entries whose parity bit disagrees with the data.
// All outputs are registered, so nothing combinational runs from num/parity
// to the ports.
module scan_checker #(
  parameter int ODD_PARITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  num,
  input  logic        parity,
  output logic [3:0]  count,
  output logic        busy,
  output logic        done,
  output logic [11:0] sum,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_addr,
  output logic        err_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ENTRY = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [11:0] sum_q, sum_d;
  logic [4:0]  err_count_q, err_count_d;
  logic [3:0]  first_err_addr_q, first_err_addr_d;
  logic        err_flag_q, err_flag_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Parity value that XOR(num, parity) must produce for a good entry.
  logic good_xor;
  logic entry_bad;

  assign good_xor  = (ODD_PARITY != 0);
  assign entry_bad = ((^num) ^ parity) != good_xor;

  // Next-state and datapath: clear on an accepted start, accumulate in SCAN.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    sum_d            = sum_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    err_flag_d       = err_flag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d          = SCAN;
          count_d          = 4'd0;
          sum_d            = 12'd0;
          err_count_d      = 5'd0;
          first_err_addr_d = 4'd0;
        end
      end
      SCAN: begin
        sum_d = sum_q + {4'd0, num};
        if (entry_bad) begin
          err_count_d = err_count_q + 5'd1;
          // Only the first bad entry of the scan records its address.
          if (err_count_q == 5'd0) first_err_addr_d = count_q;
        end
        if (count_q == LAST_ENTRY) begin
          count_d = 4'd0;
          state_d = DONE;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      DONE: begin
        // Results stay put; start is not looked at until IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are derived from the next state so they are registered
    // alongside it and line up with the state they describe.
    busy_d     = (state_d == SCAN);
    done_d     = (state_d == DONE);
    err_flag_d = (err_count_d != 5'd0);
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      count_q          <= 4'd0;
      sum_q            <= 12'd0;
      err_count_q      <= 5'd0;
      first_err_addr_q <= 4'd0;
      err_flag_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      sum_q            <= sum_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      err_flag_q       <= err_flag_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign count          = count_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sum            = sum_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign err_flag       = err_flag_q;

endmodule
